debug_rx_core: RTL and testbench
================================

# debug_rx_core

Receive-direction debug channel for the core: accepts bytes from the host-link RX FIFO over a valid/ready handshake and buffers them in a small internal FIFO. It exposes them to software as a bus-management responder on the same mgmt bus as the debug TX channel. Software polls a status register and pops bytes through a data register, which gives the debug monitor console input and host commands.

## Interface
Parameters:
- `DEPTH`, 16: internal FIFO depth in bytes; power of two, 2..256.
- `CW`, $clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_rx_vld`  in  1  byte from host link valid.
- `fifo_rx_dat`  in  8  byte from host link.
- `fifo_rx_rdy`  out  1  block can accept a byte.
- `mgmt_req`  in  1  bus request.
- `mgmt_adr`  in  32  bus address.
- `mgmt_ack`  out  1  request accepted, one-cycle pulse.
- `mgmt_rwn`  in  1  1 = read, 0 = write.
- `mgmt_wen`  in  2  write enables; this block does not use them.
- `mgmt_txd`  in  32  write data.
- `mgmt_rxe`  out  1  read data valid, one-cycle pulse.
- `mgmt_rxd`  out  32  read data; 0 whenever `mgmt_rxe` is low.
- `dbg_irq`  out  1  only when `DBGRX_IRQ_EN` is defined.

## Operation
- Address decode is `(mgmt_adr[15:0] & MASK_DBGRX) == ADDR_DBGRX_DATA` or `ADDR_DBGRX_STAT`. Any other address gets no ack and no rxe, and has no side effect.
- One transaction per `mgmt_req` assertion:
  - The `armed` flag sets on issue and clears when `mgmt_req` is low.
  - The initiator holds `mgmt_req`, `mgmt_adr`, `mgmt_rwn` and `mgmt_txd` stable until `mgmt_ack`.
  - The initiator drops `mgmt_req` for at least 1 cycle before the next transaction.
- DATA read:
  - Returns {23'b0, nonempty, byte}.
  - When nonempty, it pops the head entry.
  - When empty, it returns 0 and has no effect.
- DATA write: acked; no effect.
- STAT read returns:
  - bit31 = full, bit30 = empty.
  - bit2 = irq_en; reads 0 without the macro.
  - [CW+7:8] = occupancy count.
  - All other bits are 0.
- STAT write:
  - bit0 = flush: occupancy goes to 0 and pointers are reset.
  - bit2 = irq_en; only with the macro.
- RX side:
  - `fifo_rx_rdy = !full`, driven from registered state.
  - A byte is pushed when `fifo_rx_vld && fifo_rx_rdy`.
- Push and pop in the same cycle: both take effect and the count is unchanged. This holds for every non-full count, including a push into an empty FIFO while a stale pop is requested; in that case the pop is a no-op because empty was sampled.
- Flush has priority over push and pop in the same cycle. A byte handshaken in the flush cycle is discarded.
- Pointers wrap modulo DEPTH. The count saturates by construction at 0..DEPTH.

## Timing
- Cycle T: `mgmt_req` rises.
- T+1: the internal `issue` and the registered address match are valid. `request = issue && match`. The pop, flush and ctrl update take effect on the T+1 edge.
- T+2: `mgmt_ack` = 1. For reads, `mgmt_rxe` = 1 and `mgmt_rxd` holds the data captured at T+1, taken before the pop.
- Total latency is 2 cycles. Reads and writes complete without waits.
- A byte handshaken at edge E appears in the count and empty flag after E, and is readable by a request whose T+1 is at or after E+1.
- Reset values:
  - `mgmt_ack`, `mgmt_rxe`, `mgmt_rxd` = 0.
  - `fifo_rx_rdy` = 1.
  - `dbg_irq` = 0.
  - count = 0, irq_en = 0, armed = 0.
- Reset mid-transaction aborts it: no ack is issued after reset, and FIFO contents are lost.

## Configuration
- `DBGRX_IRQ_EN` defined:
  - Adds the `dbg_irq` output.
  - `dbg_irq = irq_en && !empty`, registered, so it has 1 cycle of lag.
  - Adds the STAT bit2 control bit.
- `DBGRX_IRQ_EN` undefined:
  - No `dbg_irq` port.
  - STAT bit2 reads 0 and writes to it are ignored.

## Structure
- `ADDR_DBGRX_DATA`, `ADDR_DBGRX_STAT`, `MASK_DBGRX` and the STAT bit positions (`DBGRX_STAT_FULL`, `_EMPTY`, `_IRQEN`, `_FLUSH`) go in `defines.v`, alongside the existing debug addresses.
- Sub-module `dbg_rx_fifo`:
  - Synchronous FIFO with `push`, `pop`, `flush`, `head`, `count`, `full` and `empty`.
  - Registered pointers; the head is read combinationally.
- The top level holds the bus responder and the status mux.

## Test plan
- Reset, then STAT read → rxd = 0x4000_0000; ack and rxe at T+2.
- Push 0x41 then 0x42, then DATA read twice → rxd = 0x0000_0141, then 0x0000_0142. A third DATA read → 0x0000_0000.
- Push DEPTH bytes → `fifo_rx_rdy` = 0 and STAT bit31 = 1. Then DATA read at the same time as `fifo_rx_vld` is high → the head pops and `rdy` rises the next cycle. Then push one more byte → the FIFO is full again and the order is preserved across the wrap.
- Hold `mgmt_req` high for 6 cycles on a DATA read → exactly one ack and one pop.
- STAT write 0x1 while `fifo_rx_vld` = 1 with 3 bytes queued → count = 0 and the concurrent byte is dropped. Address 0x…(unmatched) → no ack.
- With `DBGRX_IRQ_EN`: write STAT 0x4, then push 1 byte → `dbg_irq` = 1 one cycle after the count update. Pop the byte → `dbg_irq` = 0.

Source files
------------

// File: rtl/debug_rx_core_pkg.sv
// Shared constants for the debug RX channel: mgmt register map, STAT bit positions
// and the address decode helper.
package debug_rx_core_pkg;

    localparam logic [15:0] MASK_DBGRX      = 16'hFFFC;
    localparam logic [15:0] ADDR_DBGRX_DATA = 16'h0030;
    localparam logic [15:0] ADDR_DBGRX_STAT = 16'h0034;

    localparam int DBGRX_STAT_FULL  = 31;
    localparam int DBGRX_STAT_EMPTY = 30;
    localparam int DBGRX_STAT_IRQEN = 2;
    localparam int DBGRX_STAT_FLUSH = 0;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DATA = 2'd1,
        SEL_STAT = 2'd2
    } dbgrx_sel_e;

    function automatic dbgrx_sel_e dbgrx_decode(input logic [15:0] adr);
        logic [15:0] masked;
        masked = adr & MASK_DBGRX;
        if (masked == ADDR_DBGRX_DATA) begin
            return SEL_DATA;
        end else if (masked == ADDR_DBGRX_STAT) begin
            return SEL_STAT;
        end else begin
            return SEL_NONE;
        end
    endfunction

endpackage

// File: rtl/dbg_rx_fifo.sv
// Byte FIFO for the debug RX channel: registered pointers and count, head read
// combinationally; flush overrides push and pop.
module dbg_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/count state; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/debug_rx_core.sv
// Debug RX channel: host-link bytes buffered in dbg_rx_fifo and popped by software
// over the mgmt bus. Optional interrupt output enabled by the DBGRX_IRQ_EN macro.
module debug_rx_core
    import debug_rx_core_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rx_vld,
    input  logic [7:0]  fifo_rx_dat,
    output logic        fifo_rx_rdy,
    input  logic        mgmt_req,
    input  logic [31:0] mgmt_adr,
    output logic        mgmt_ack,
    input  logic        mgmt_rwn,
    input  logic [1:0]  mgmt_wen,
    input  logic [31:0] mgmt_txd,
    output logic        mgmt_rxe,
    output logic [31:0] mgmt_rxd
`ifdef DBGRX_IRQ_EN
    ,
    output logic        dbg_irq
`endif
);

    logic          armed_q, armed_d;
    logic          issue_q, issue_d;
    dbgrx_sel_e    sel_q, sel_d;
    logic          ack_q, ack_d;
    logic          rxe_q, rxe_d;
    logic [31:0]   rxd_q, rxd_d;
    logic          request_s, pop_s, flush_s, push_s, irq_en_s;
    logic [31:0]   rd_data_s;
    logic [7:0]    head_s;
    logic [CW-1:0] count_s;
    logic          full_s, empty_s;
    logic          unused_s;

    assign unused_s    = ^{mgmt_wen, mgmt_adr[31:16], mgmt_txd};
    assign fifo_rx_rdy = !full_s;
    assign push_s      = fifo_rx_vld && !full_s;
    assign mgmt_ack    = ack_q;
    assign mgmt_rxe    = rxe_q;
    assign mgmt_rxd    = rxd_q;

    dbg_rx_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (fifo_rx_dat),
        .pop   (pop_s),
        .flush (flush_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Bus responder: one transaction per rising edge of mgmt_req, read data captured before the pop
    always_comb begin
        armed_d   = mgmt_req;
        issue_d   = mgmt_req && !armed_q;
        sel_d     = dbgrx_decode(mgmt_adr[15:0]);
        request_s = issue_q && (sel_q != SEL_NONE);
        rd_data_s = 32'h0000_0000;
        pop_s     = 1'b0;
        flush_s   = 1'b0;
        case (sel_q)
            SEL_DATA: begin
                rd_data_s[8] = !empty_s;
                if (empty_s) begin
                    rd_data_s[7:0] = 8'h00;
                end else begin
                    rd_data_s[7:0] = head_s;
                end
                pop_s = request_s && mgmt_rwn;
            end
            SEL_STAT: begin
                rd_data_s[DBGRX_STAT_FULL]  = full_s;
                rd_data_s[DBGRX_STAT_EMPTY] = empty_s;
                rd_data_s[DBGRX_STAT_IRQEN] = irq_en_s;
                rd_data_s[8 +: CW]          = count_s;
                flush_s = request_s && !mgmt_rwn && mgmt_txd[DBGRX_STAT_FLUSH];
            end
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
        ack_d = request_s;
        rxe_d = request_s && mgmt_rwn;
        if (rxe_d) begin
            rxd_d = rd_data_s;
        end else begin
            rxd_d = 32'h0000_0000;
        end
    end

    // Responder registers; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            issue_q <= 1'b0;
            sel_q   <= SEL_NONE;
            ack_q   <= 1'b0;
            rxe_q   <= 1'b0;
            rxd_q   <= 32'h0000_0000;
        end else begin
            armed_q <= armed_d;
            issue_q <= issue_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            rxe_q   <= rxe_d;
            rxd_q   <= rxd_d;
        end
    end

`ifdef DBGRX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq_en_s = irq_en_q;
    assign dbg_irq  = irq_q;

    // Interrupt enable updated by STAT writes; irq lags the FIFO state by one cycle
    always_comb begin
        if (request_s && !mgmt_rwn && (sel_q == SEL_STAT)) begin
            irq_en_d = mgmt_txd[DBGRX_STAT_IRQEN];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = irq_en_q && !empty_s;
    end

    // Interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en_s = 1'b0;
`endif

endmodule

// File: tb/tb_debug_rx_core.sv
// Directed self-checking bench for debug_rx_core (DEPTH = 16).
module tb_debug_rx_core;

    localparam logic [31:0] A_DATA = 32'h0000_0030;
    localparam logic [31:0] A_STAT = 32'h0000_0034;
    localparam logic [31:0] A_NONE = 32'h0000_0038;
    localparam logic [34:0] WR_OK  = {3'b010, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        req;
    logic [31:0] adr;
    logic        ack;
    logic        rwn;
    logic [1:0]  wen;
    logic [31:0] txd;
    logic        rxe;
    logic [31:0] rxd;
`ifdef DBGRX_IRQ_EN
    logic        irq;
`endif

    int vectors     = 0;
    int miscompares = 0;

    debug_rx_core dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rx_vld (vld),
        .fifo_rx_dat (dat),
        .fifo_rx_rdy (rdy),
        .mgmt_req    (req),
        .mgmt_adr    (adr),
        .mgmt_ack    (ack),
        .mgmt_rwn    (rwn),
        .mgmt_wen    (wen),
        .mgmt_txd    (txd),
        .mgmt_rxe    (rxe),
        .mgmt_rxd    (rxd)
`ifdef DBGRX_IRQ_EN
        ,
        .dbg_irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; obs = {ack|rxe at T+1, ack at T+2, rxe at T+2, rxd at T+2}
    task automatic xfer(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        output logic [34:0] obs);
        logic early;
        req = 1'b1; adr = a; rwn = rw; txd = wd;
        tick;
        early = ack | rxe;
        tick;
        obs = {early, ack, rxe, rxd};
        req = 1'b0;
        tick;
    endtask

    task automatic push_byte(input logic [7:0] b);
        vld = 1'b1; dat = b;
        tick;
        vld = 1'b0;
    endtask

    task automatic test_reset;
        logic [34:0] obs;
        rst = 1'b1; vld = 1'b0; dat = 8'h00; req = 1'b0; adr = 32'h0;
        rwn = 1'b0; wen = 2'b00; txd = 32'h0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        vectors++;
        if ({ack, rxe, rxd, rdy} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_outputs got ack=%b rxe=%b rxd=%h rdy=%b want 0 0 00000000 1", ack, rxe, rxd, rdy);
        end
`ifdef DBGRX_IRQ_EN
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
`endif
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0000}) begin miscompares++; $display("FAIL reset_stat got %h want %h", obs, {3'b011, 32'h4000_0000}); end
    endtask

    task automatic test_order;
        logic [34:0] obs;
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h0000_0200; exp_q[1] = 32'h0000_0141;
        exp_q[2] = 32'h0000_0142; exp_q[3] = 32'h0000_0000;
        push_byte(8'h41);
        push_byte(8'h42);
        for (int i = 0; i < 4; i++) begin
            xfer((i == 0) ? A_STAT : A_DATA, 1'b1, 32'h0, obs);
            vectors++;
            if (obs !== {3'b011, exp_q[i]}) begin miscompares++; $display("FAIL order_rd%0d got %h want %h", i, obs, {3'b011, exp_q[i]}); end
        end
    endtask

    task automatic test_full_wrap;
        logic [34:0] obs;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        vectors++;
        if (rdy !== 1'b0) begin miscompares++; $display("FAIL full_rdy got %b want 0", rdy); end
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h8000_1000}) begin miscompares++; $display("FAIL full_stat got %h want %h", obs, {3'b011, 32'h8000_1000}); end
        // DATA read while the link keeps offering 0xEE
        req = 1'b1; adr = A_DATA; rwn = 1'b1; vld = 1'b1; dat = 8'hEE;
        tick;
        vectors++;
        if (rdy !== 1'b0) begin miscompares++; $display("FAIL full_pop_rdy_t1 got %b want 0", rdy); end
        tick;
        vectors++;
        if ({ack, rxe, rxd, rdy} !== {1'b1, 1'b1, 32'h0000_0110, 1'b1}) begin
            miscompares++;
            $display("FAIL full_pop got ack=%b rxe=%b rxd=%h rdy=%b want 1 1 00000110 1", ack, rxe, rxd, rdy);
        end
        req = 1'b0;
        tick;
        vld = 1'b0;
        vectors++;
        if (rdy !== 1'b0) begin miscompares++; $display("FAIL refill_rdy got %b want 0", rdy); end
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] want;
            want = (i == 16) ? 32'h0000_01EE : (32'h0000_0110 + 32'(i));
            xfer(A_DATA, 1'b1, 32'h0, obs);
            vectors++;
            if (obs !== {3'b011, want}) begin miscompares++; $display("FAIL wrap_rd%0d got %h want %h", i, obs, {3'b011, want}); end
        end
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0000}) begin miscompares++; $display("FAIL wrap_stat got %h want %h", obs, {3'b011, 32'h4000_0000}); end
    endtask

    task automatic test_hold_req;
        logic [34:0] obs;
        int          acks;
        logic [31:0] got;
        push_byte(8'h55);
        push_byte(8'h66);
        acks = 0; got = 32'h0;
        req = 1'b1; adr = A_DATA; rwn = 1'b1;
        repeat (6) begin
            tick;
            if (ack === 1'b1) begin acks++; got = rxd; end
        end
        req = 1'b0;
        tick;
        vectors++;
        if (acks !== 1 || got !== 32'h0000_0155) begin miscompares++; $display("FAIL hold_once got acks=%0d rxd=%h want 1 00000155", acks, got); end
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_0100}) begin miscompares++; $display("FAIL hold_stat got %h want %h", obs, {3'b011, 32'h0000_0100}); end
        xfer(A_DATA, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_0166}) begin miscompares++; $display("FAIL hold_rd got %h want %h", obs, {3'b011, 32'h0000_0166}); end
    endtask

    task automatic test_same_cycle;
        logic [34:0] obs;
        logic [31:0] want_pop [2];
        want_pop[0] = 32'h0000_0131; want_pop[1] = 32'h0000_0000;
        push_byte(8'h31);
        for (int k = 0; k < 2; k++) begin
            // push lands on the same edge the pop takes effect
            req = 1'b1; adr = A_DATA; rwn = 1'b1;
            tick;
            vld = 1'b1; dat = 8'h32 + 8'(k);
            tick;
            vld = 1'b0;
            vectors++;
            if ({ack, rxe, rxd} !== {1'b1, 1'b1, want_pop[k]}) begin
                miscompares++;
                $display("FAIL same_pop%0d got ack=%b rxe=%b rxd=%h want 1 1 %h", k, ack, rxe, rxd, want_pop[k]);
            end
            req = 1'b0;
            tick;
            xfer(A_STAT, 1'b1, 32'h0, obs);
            vectors++;
            if (obs !== {3'b011, 32'h0000_0100}) begin miscompares++; $display("FAIL same_stat%0d got %h want %h", k, obs, {3'b011, 32'h0000_0100}); end
            xfer(A_DATA, 1'b1, 32'h0, obs);
            vectors++;
            if (obs !== {3'b011, 32'h0000_0132 + 32'(k)}) begin miscompares++; $display("FAIL same_rd%0d got %h want %h", k, obs, {3'b011, 32'h0000_0132 + 32'(k)}); end
        end
    endtask

    task automatic test_flush_write;
        logic [34:0] obs;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        req = 1'b1; adr = A_STAT; rwn = 1'b0; txd = 32'h0000_0001;
        tick;
        vld = 1'b1; dat = 8'h77;
        tick;
        vld = 1'b0;
        vectors++;
        if ({ack, rxe, rxd} !== {1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL flush_ack got ack=%b rxe=%b rxd=%h want 1 0 00000000", ack, rxe, rxd); end
        req = 1'b0;
        tick;
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0000}) begin miscompares++; $display("FAIL flush_stat got %h want %h", obs, {3'b011, 32'h4000_0000}); end
        xfer(A_DATA, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0}) begin miscompares++; $display("FAIL flush_rd got %h want %h", obs, {3'b011, 32'h0}); end
        push_byte(8'h12);
        xfer(A_DATA, 1'b0, 32'hFFFF_FFFF, obs);
        vectors++;
        if (obs !== WR_OK) begin miscompares++; $display("FAIL data_wr got %h want %h", obs, WR_OK); end
        xfer(A_DATA, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_0112}) begin miscompares++; $display("FAIL data_wr_rd got %h want %h", obs, {3'b011, 32'h0000_0112}); end
    endtask

    task automatic test_unmatched;
        logic [34:0] obs;
        int          seen;
        push_byte(8'h5A);
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            req = 1'b1; adr = A_NONE; rwn = (k == 0); txd = 32'h0000_0001;
            repeat (4) begin
                tick;
                if (ack !== 1'b0 || rxe !== 1'b0) seen++;
            end
            req = 1'b0;
            tick;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL unmatched_ack got %0d responses want 0", seen); end
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_0100}) begin miscompares++; $display("FAIL unmatched_stat got %h want %h", obs, {3'b011, 32'h0000_0100}); end
        xfer(32'hABCD_0030, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_015A}) begin miscompares++; $display("FAIL upper_adr_rd got %h want %h", obs, {3'b011, 32'h0000_015A}); end
    endtask

    task automatic test_irq;
        logic [34:0] obs;
        xfer(A_STAT, 1'b0, 32'h0000_0004, obs);
        vectors++;
        if (obs !== WR_OK) begin miscompares++; $display("FAIL irqen_wr got %h want %h", obs, WR_OK); end
`ifdef DBGRX_IRQ_EN
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0004}) begin miscompares++; $display("FAIL irqen_stat got %h want %h", obs, {3'b011, 32'h4000_0004}); end
        push_byte(8'h99);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lag got %b want 0", irq); end
        tick;
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise got %b want 1", irq); end
        xfer(A_DATA, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h0000_0199} || irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall got %h irq=%b want %h irq=0", obs, irq, {3'b011, 32'h0000_0199}); end
        xfer(A_STAT, 1'b0, 32'h0, obs);
`else
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0000}) begin miscompares++; $display("FAIL irqen_ignored got %h want %h", obs, {3'b011, 32'h4000_0000}); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [34:0] obs;
        int          seen;
        push_byte(8'h44);
        req = 1'b1; adr = A_DATA; rwn = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; req = 1'b0;
        seen = 0;
        repeat (3) begin
            if (ack !== 1'b0 || rxe !== 1'b0) seen++;
            tick;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL reset_abort got %0d responses want 0", seen); end
        xfer(A_STAT, 1'b1, 32'h0, obs);
        vectors++;
        if (obs !== {3'b011, 32'h4000_0000}) begin miscompares++; $display("FAIL reset_lost got %h want %h", obs, {3'b011, 32'h4000_0000}); end
    endtask

    initial begin
        test_reset;
        test_order;
        test_full_wrap;
        test_hold_req;
        test_same_cycle;
        test_flush_write;
        test_unmatched;
        test_irq;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
